// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blink_pkg
// Brief    : Command op codes, controller states and default LED patterns.
// Revision : 1.0
// ============================================================================
package blink_pkg;

    localparam logic [1:0] OP_SET_PERIOD  = 2'd0;
    localparam logic [1:0] OP_SET_PATTERN = 2'd1;
    localparam logic [1:0] OP_RUN         = 2'd2;
    localparam logic [1:0] OP_STOP        = 2'd3;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam logic [7:0] c_DEF_PAT_A = 8'hFF;
    localparam logic [7:0] c_DEF_PAT_B = 8'h00;

endpackage
`default_nettype wire

// File: rtl/blink_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : blink_sequencer_if
// Brief    : Valid/ready command channel from the remote command decoder.
// Revision : 1.0
// ============================================================================
interface blink_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/blink_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : blink_phase_timer
// Brief    : Phase counter 0..period-1 with clear; pulses tick on terminal count.
// Revision : 1.0
// ============================================================================
module blink_phase_timer #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_clr,
    input  wire logic [CNT_W-1:0] i_period,
    output logic                  o_tick
);

    logic [CNT_W-1:0] r_count;
    logic             w_tick;

    assign w_tick = i_en && (r_count == (i_period - CNT_W'(1)));
    assign o_tick = w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_tick ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : blink_sequencer
// Brief    : Command-driven LED sequencer alternating pattern A/B per phase.
// Revision : 1.0
// ============================================================================
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int CLK_FREQ    = 25_000_000,
    parameter int DEFAULT_DIV = 4,
    parameter int CNT_W       = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    blink_sequencer_if.slave cmd,
    output logic [7:0]      leds,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [CNT_W-1:0] c_DEFAULT_PERIOD = CNT_W'(CLK_FREQ / DEFAULT_DIV);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_pend_period;
    logic [CNT_W-1:0] r_act_period;
    logic [7:0]       r_pat_a;
    logic [7:0]       r_pat_b;
    logic [15:0]      r_remaining;
    logic             r_phase;
    logic [7:0]       r_leds;
    logic             r_done;
    logic             r_err;

    logic [7:0]       w_leds_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_run_cmd;
    logic             w_stop_cmd;
    logic             w_setp_cmd;
    logic             w_setpat_cmd;
    logic             w_period_zero;
    logic             w_in_run;
    logic             w_tick;
    logic             w_boundary;
    logic             w_last;

    assign w_run_cmd     = cmd.cmd_valid && (cmd.cmd_op == OP_RUN);
    assign w_stop_cmd    = cmd.cmd_valid && (cmd.cmd_op == OP_STOP);
    assign w_setp_cmd    = cmd.cmd_valid && (cmd.cmd_op == OP_SET_PERIOD);
    assign w_setpat_cmd  = cmd.cmd_valid && (cmd.cmd_op == OP_SET_PATTERN);
    assign w_period_zero = (cmd.cmd_data[CNT_W-1:0] == '0);
    assign w_in_run      = (r_state == ST_RUN);

    // RUN/STOP commands take precedence over a coincident phase boundary
    assign w_boundary = w_in_run && w_tick && !w_run_cmd && !w_stop_cmd;
    assign w_last     = w_boundary && (r_remaining == 16'd1);

    blink_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_in_run),
        .i_clr    (w_run_cmd || w_stop_cmd || !w_in_run),
        .i_period (r_act_period),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_run_cmd) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_run_cmd)                 w_state_nxt = ST_RUN;
                else if (w_stop_cmd || w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_leds_nxt = r_leds;
        w_done_nxt = w_last;
        w_err_nxt  = w_setp_cmd && w_period_zero;
        if (w_run_cmd) begin
            w_leds_nxt = r_pat_a;
        end else if (w_stop_cmd || w_last || !w_in_run) begin
            w_leds_nxt = '0;
        end else if (w_boundary) begin
            // r_phase is the phase ending now; show the other pattern next
            w_leds_nxt = r_phase ? r_pat_a : r_pat_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_period <= c_DEFAULT_PERIOD;
            r_act_period  <= c_DEFAULT_PERIOD;
            r_pat_a       <= c_DEF_PAT_A;
            r_pat_b       <= c_DEF_PAT_B;
            r_remaining   <= '0;
            r_phase       <= 1'b0;
            r_leds        <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_leds <= w_leds_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;

            if (w_setp_cmd && !w_period_zero) begin
                r_pend_period <= cmd.cmd_data[CNT_W-1:0];
            end
            if (w_setpat_cmd) begin
                r_pat_a <= cmd.cmd_data[7:0];
                r_pat_b <= cmd.cmd_data[15:8];
            end

            // Active period picks up the pre-write pending value
            if (w_run_cmd) begin
                r_act_period <= r_pend_period;
                r_remaining  <= cmd.cmd_data[15:0];
                r_phase      <= 1'b0;
            end else if (w_boundary) begin
                r_act_period <= r_pend_period;
                r_phase      <= ~r_phase;
                if (r_remaining != 16'd0) begin
                    r_remaining <= r_remaining - 16'd1;
                end
            end
        end
    end

    assign cmd.cmd_ready = 1'b1;
    assign leds          = r_leds;
    assign busy          = w_in_run;
    assign done          = r_done;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_blink_sequencer
// Brief    : Scoreboard bench: phase-schedule reference model vs blink_sequencer.
// Revision : 1.0
// ============================================================================
module tb_blink_sequencer;

    localparam int CLK_FREQ    = 40;
    localparam int DEFAULT_DIV = 4;
    localparam int CNT_W       = 32;
    localparam int DEF_PERIOD  = CLK_FREQ / DEFAULT_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] leds;
    logic       busy;
    logic       done;
    logic       err;

    blink_sequencer_if cmd_bus ();

    blink_sequencer #(
        .CLK_FREQ    (CLK_FREQ),
        .DEFAULT_DIV (DEFAULT_DIV),
        .CNT_W       (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd_bus),
        .leds (leds),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  leds;
        logic        busy;
        logic        done;
        logic        err;
        logic        ready;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a run is a list of phases; phase i starts at an absolute
    // cycle and lasts the period latched at its start; even phases show A.
    bit          m_run  = 1'b0;
    int unsigned m_pend = DEF_PERIOD;
    int unsigned m_act  = DEF_PERIOD;
    logic [7:0]  m_pa   = 8'hFF;
    logic [7:0]  m_pb   = 8'h00;
    logic [7:0]  m_leds = 8'h00;
    int          m_idx  = 0;
    int          m_n    = 0;
    int unsigned m_start = 0;

    task automatic step(input bit r, input bit v, input logic [1:0] op, input logic [31:0] d);
        exp_t        e;
        bit          bnd;
        int unsigned new_pend;
        logic [7:0]  npa;
        logic [7:0]  npb;
        @(posedge clk);
        #1;
        rst = r;
        cmd_bus.cmd_valid = v;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = d;
        e.done  = 1'b0;
        e.err   = 1'b0;
        e.ready = 1'b1;
        if (r) begin
            m_pend = DEF_PERIOD;
            m_act  = DEF_PERIOD;
            m_pa   = 8'hFF;
            m_pb   = 8'h00;
            m_run  = 1'b0;
            m_leds = 8'h00;
        end else begin
            new_pend = m_pend;
            npa      = m_pa;
            npb      = m_pb;
            bnd = m_run && (cyc == m_start + m_act - 1);
            if (v && op == 2'd0) begin
                if (d == 32'd0) e.err = 1'b1;
                else            new_pend = d;
            end
            if (v && op == 2'd1) begin
                npa = d[7:0];
                npb = d[15:8];
            end
            if (v && op == 2'd2) begin
                m_run   = 1'b1;
                m_act   = m_pend;
                m_idx   = 0;
                m_n     = int'(d[15:0]);
                m_start = cyc + 1;
                m_leds  = m_pa;
            end else if (v && op == 2'd3) begin
                m_run  = 1'b0;
                m_leds = 8'h00;
            end else if (bnd) begin
                if (m_n != 0 && m_idx + 1 == m_n) begin
                    m_run  = 1'b0;
                    m_leds = 8'h00;
                    e.done = 1'b1;
                end else begin
                    m_idx   = m_idx + 1;
                    m_act   = m_pend;
                    m_start = cyc + 1;
                    m_leds  = (m_idx % 2 == 0) ? m_pa : m_pb;
                end
            end
            m_pend = new_pend;
            m_pa   = npa;
            m_pb   = npb;
        end
        e.leds = m_leds;
        e.busy = m_run;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] d);
        step(1'b0, 1'b1, op, d);
    endtask

    // Monitor: outputs registered at posedge k are compared on the following negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                e = sb_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_sample cyc=%0d: expectation never compared (now cyc=%0d)", e.cyc, cyc);
            end
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (leds !== e.leds || busy !== e.busy || done !== e.done ||
                    err !== e.err || cmd_bus.cmd_ready !== e.ready) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d: got leds=%h busy=%b done=%b err=%b ready=%b, want leds=%h busy=%b done=%b err=%b ready=%b",
                             cyc, leds, busy, done, err, cmd_bus.cmd_ready,
                             e.leds, e.busy, e.done, e.err, e.ready);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        logic [31:0] dat;
        logic [1:0]  op;
        int          w;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'd0;
        cmd_bus.cmd_data  = 32'd0;

        // Reset then idle
        step(1'b1, 1'b0, 2'd0, 32'd0);
        step(1'b1, 1'b0, 2'd0, 32'd0);
        idle(3);

        // Counted run of three phases
        send(2'd0, 32'd4);
        send(2'd1, 32'h0000_5AA5);
        send(2'd2, 32'd3);
        idle(16);

        // Zero period is rejected; run keeps period 4
        send(2'd0, 32'd0);
        send(2'd2, 32'd2);
        idle(12);

        // Free-running run then STOP
        send(2'd0, 32'd2);
        send(2'd2, 32'd0);
        idle(40);
        send(2'd3, 32'd0);
        idle(5);

        // Period change mid-phase applies from the following phase
        send(2'd0, 32'd4);
        send(2'd2, 32'd0);
        idle(1);
        send(2'd0, 32'd6);
        idle(20);
        send(2'd3, 32'd0);
        idle(2);

        // Reset mid-run, then a single phase at the default period
        send(2'd2, 32'd0);
        idle(2);
        step(1'b1, 1'b0, 2'd0, 32'd0);
        send(2'd2, 32'd1);
        idle(14);

        // STOP while idle is a no-op
        send(2'd3, 32'd0);
        idle(2);

        // Randomized command traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, 1'b0, 2'd0, 32'd0);
            end else if ($urandom_range(0, 9) < 2) begin
                rnd = $urandom;
                op  = 2'($urandom_range(0, 3));
                case (op)
                    2'd0:    dat = 32'($urandom_range(0, 7));
                    2'd1:    dat = rnd;
                    2'd2:    dat = {rnd[31:16], 16'($urandom_range(0, 5))};
                    default: dat = rnd;
                endcase
                send(op, dat);
            end else begin
                idle(1);
            end
        end
        idle(2);

        w = 0;
        while (sb_q.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
